// File: rtl/dmem_access.sv
// Data-memory access unit for the memory stage.
// Validates and aligns a load/store, runs a valid/ready request to data memory,
// waits for read data on loads, and extracts/extends the loaded byte, halfword or word.
module dmem_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid,
  input  logic        re,
  input  logic [3:0]  w_mask,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_re,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Fields captured when an access is accepted; held stable through REQ/WAIT.
  logic [31:0] addr_q;
  logic        re_q;
  logic [2:0]  funct3_q;
  logic [3:0]  wmask_q;
  logic [31:0] wdata_q;

  logic [31:0] load_q;
  logic        err_q;

  // Decode results for the incoming op.
  logic        is_store;
  logic        noop;
  logic        size_ok;
  logic        align_ok;
  logic        legal;
  logic        accept;
  logic        reject;
  logic [3:0]  wmask_al;
  logic [31:0] wdata_al;

  // Load extraction results.
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  // Classify the incoming op: width from funct3 for loads, from w_mask for stores.
  always_comb begin
    is_store = (w_mask != '0);
    noop     = !re && !is_store;
    size_ok  = 1'b0;
    align_ok = 1'b0;
    if (re && !is_store) begin
      case (funct3)
        3'b000, 3'b100: begin
          size_ok  = 1'b1;
          align_ok = 1'b1;
        end
        3'b001, 3'b101: begin
          size_ok  = 1'b1;
          align_ok = !addr[0];
        end
        3'b010: begin
          size_ok  = 1'b1;
          align_ok = (addr[1:0] == 2'b00);
        end
        default: ;
      endcase
    end else if (!re && is_store) begin
      case (w_mask)
        4'b0001: begin
          size_ok  = 1'b1;
          align_ok = 1'b1;
        end
        4'b0011: begin
          size_ok  = 1'b1;
          align_ok = !addr[0];
        end
        4'b1111: begin
          size_ok  = 1'b1;
          align_ok = (addr[1:0] == 2'b00);
        end
        default: ;
      endcase
    end
    // Both re and a mask set falls through with size_ok=0 and is rejected.
    legal    = size_ok && align_ok;
    accept   = (state == S_IDLE) && valid && legal;
    reject   = (state == S_IDLE) && valid && !noop && !legal;
    wmask_al = w_mask << addr[1:0];
    wdata_al = wdata << {addr[1:0], 3'b000};
  end

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    rbyte = 8'(mem_resp_data >> {addr_q[1:0], 3'b000});
    rhalf = 16'(mem_resp_data >> {addr_q[1], 4'b0000});
    case (funct3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext = {24'd0, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext = {16'd0, rhalf};
      default: ext = mem_resp_data;
    endcase
  end

  // Next-state logic for the access sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready) state_nxt = re_q ? S_WAIT : S_DONE;
      S_WAIT: if (mem_resp_valid) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request field capture, error pulse and load result register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      re_q     <= 1'b0;
      funct3_q <= '0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      load_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        addr_q   <= addr;
        re_q     <= re;
        funct3_q <= funct3;
        wmask_q  <= wmask_al;
        wdata_q  <= wdata_al;
      end
      if ((state == S_REQ) && mem_req_ready && !re_q) begin
        load_q <= '0;
      end
      if ((state == S_WAIT) && mem_resp_valid) begin
        load_q <= ext;
      end
    end
  end

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_re    = (state == S_REQ) && re_q;
  assign mem_req_wmask = (state == S_REQ) ? wmask_q : '0;
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_wdata = wdata_q;
  assign busy          = (state == S_REQ) || (state == S_WAIT) || accept;
  assign done          = (state == S_DONE);
  assign err           = err_q;
  assign load_data     = load_q;

endmodule

// File: tb/tb_dmem_access.sv
// Randomized bench for dmem_access with a transaction-level reference model.
module tb_dmem_access;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic        re;
  logic [3:0]  w_mask;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_re;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        err;

  int n_cmp;
  int n_bad;

  dmem_access dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid          (valid),
    .re             (re),
    .w_mask         (w_mask),
    .funct3         (funct3),
    .addr           (addr),
    .wdata          (wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_re     (mem_req_re),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy),
    .done           (done),
    .load_data      (load_data),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes, 0 when the op has no valid width.
  function automatic int unsigned acc_size(input logic r, input logic [3:0] m, input logic [2:0] f);
    if (r && m == 4'd0) begin
      case (f)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    if (!r) begin
      if (m == 4'd1)  return 1;
      if (m == 4'd3)  return 2;
      if (m == 4'd15) return 4;
    end
    return 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
    int unsigned off;
    int unsigned v;
    off = a % 4;
    case (f)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) % 256;
        if (f == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (off / 2))) % 65536;
        if (f == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One complete access, from presentation in IDLE through the DONE cycle.
  task automatic do_access(input logic r, input logic [3:0] m, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d,
                           input int unsigned rdy_dly, input int unsigned rsp_dly,
                           input logic [31:0] rsp_word);
    int unsigned sz;
    int unsigned off;
    logic        nop;
    logic        lgl;
    logic [31:0] model_ld;
    logic [31:0] ewd;
    logic [3:0]  ewm;
    sz  = acc_size(r, m, f);
    nop = !r && (m == 4'd0);
    lgl = (sz != 0) && ((a % 32'(sz)) == 0);
    off = a % 4;
    ewm = 4'((m * (32'd1 << off)) % 16);
    ewd = d * (32'd1 << (8 * off));

    tick();
    valid          = 1'b1;
    re             = r;
    w_mask         = m;
    funct3         = f;
    addr           = a;
    wdata          = d;
    mem_req_ready  = 1'($urandom);
    mem_resp_valid = 1'($urandom);
    mem_resp_data  = $urandom;
    #1;
    chk("busy_present", 32'(busy), 32'(lgl));
    chk("reqv_idle", 32'(mem_req_valid), 0);
    tick();
    valid          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    if (!lgl) begin
      chk("err", 32'(err), 32'(!nop));
      chk("reqv_noreq", 32'(mem_req_valid), 0);
      chk("busy_noreq", 32'(busy), 0);
      chk("done_noreq", 32'(done), 0);
      tick();
      chk("err_after", 32'(err), 0);
      return;
    end

    for (int unsigned k = 0; k <= rdy_dly; k++) begin
      mem_req_ready  = (k == rdy_dly);
      mem_resp_valid = 1'($urandom);
      #1;
      chk("reqv", 32'(mem_req_valid), 1);
      chk("req_addr", mem_req_addr, a & ~32'd3);
      chk("req_re", 32'(mem_req_re), 32'(r));
      chk("req_wmask", 32'(mem_req_wmask), r ? 32'd0 : 32'(ewm));
      if (!r) chk("req_wdata", mem_req_wdata, ewd);
      chk("busy_req", 32'(busy), 1);
      chk("done_req", 32'(done), 0);
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;

    if (r) begin
      for (int unsigned k = 0; k <= rsp_dly; k++) begin
        mem_req_ready  = 1'($urandom);
        mem_resp_valid = (k == rsp_dly);
        mem_resp_data  = (k == rsp_dly) ? rsp_word : $urandom;
        #1;
        chk("reqv_wait", 32'(mem_req_valid), 0);
        chk("wmask_wait", 32'(mem_req_wmask), 0);
        chk("busy_wait", 32'(busy), 1);
        chk("done_wait", 32'(done), 0);
        tick();
      end
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      model_ld = exp_load(rsp_word, a, f);
    end else begin
      model_ld = 32'd0;
    end

    // A legal word load offered during DONE must not start a new request.
    valid  = 1'b1;
    re     = 1'b1;
    w_mask = 4'd0;
    funct3 = 3'd2;
    addr   = 32'h100;
    #1;
    chk("done", 32'(done), 1);
    chk("load_data", load_data, model_ld);
    chk("busy_done", 32'(busy), 0);
    chk("reqv_done", 32'(mem_req_valid), 0);
    tick();
    valid = 1'b0;
    #1;
    chk("done_pulse", 32'(done), 0);
    chk("reqv_after", 32'(mem_req_valid), 0);
    chk("err_after_done", 32'(err), 0);
    chk("load_hold", load_data, model_ld);
  endtask

  initial begin
    logic        r;
    logic [3:0]  m;
    logic [2:0]  f;
    logic [31:0] a;
    int unsigned sel;
    logic [2:0]  lf [5];
    logic [3:0]  sm [3];
    lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
    sm[0] = 4'd1; sm[1] = 4'd3; sm[2] = 4'd15;

    n_cmp          = 0;
    n_bad          = 0;
    reset_n        = 1'b0;
    valid          = 1'b0;
    re             = 1'b0;
    w_mask         = 4'd0;
    funct3         = 3'd0;
    addr           = 32'd0;
    wdata          = 32'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;

    repeat (3) tick();
    chk("rst_reqv", 32'(mem_req_valid), 0);
    chk("rst_re", 32'(mem_req_re), 0);
    chk("rst_wmask", 32'(mem_req_wmask), 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_wdata", mem_req_wdata, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_load", load_data, 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;

    // SB at byte 3, LB with two WAIT cycles, LHU upper half, misaligned LW, SW with slow ready
    do_access(1'b0, 4'b0001, 3'd0, 32'h1003, 32'h000000AB, 0, 0, 32'd0);
    do_access(1'b1, 4'b0000, 3'd0, 32'h2001, 32'd0, 0, 2, 32'h12348056);
    do_access(1'b1, 4'b0000, 3'd5, 32'h2002, 32'd0, 1, 0, 32'hBEEF0000);
    do_access(1'b1, 4'b0000, 3'd2, 32'h2002, 32'd0, 0, 0, 32'd0);
    do_access(1'b0, 4'b1111, 3'd2, 32'h3000, 32'hCAFEF00D, 3, 0, 32'd0);
    do_access(1'b0, 4'b0000, 3'd0, 32'h3000, 32'd0, 0, 0, 32'd0);
    do_access(1'b1, 4'b0011, 3'd1, 32'h3000, 32'd0, 0, 0, 32'd0);
    do_access(1'b1, 4'b0000, 3'd3, 32'h3000, 32'd0, 0, 0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(9, 0);
      a   = 32'h4000 + 32'($urandom_range(63, 0));
      if (sel < 4) begin
        r = 1'b1;
        m = 4'd0;
        f = ($urandom_range(4, 0) == 0) ? 3'($urandom) : lf[$urandom_range(4, 0)];
      end else if (sel < 8) begin
        r = 1'b0;
        m = sm[$urandom_range(2, 0)];
        f = 3'($urandom);
      end else if (sel == 8) begin
        r = 1'b0;
        m = 4'd0;
        f = 3'($urandom);
      end else begin
        r = 1'b1;
        m = sm[$urandom_range(2, 0)];
        f = lf[$urandom_range(4, 0)];
      end
      do_access(r, m, f, a, $urandom, $urandom_range(3, 0), $urandom_range(3, 0), $urandom);
    end

    // Leave a nonzero load result, then reset while waiting for read data.
    do_access(1'b1, 4'b0000, 3'd2, 32'h5000, 32'd0, 0, 0, 32'hDEADBEEF);
    tick();
    valid  = 1'b1;
    re     = 1'b1;
    w_mask = 4'd0;
    funct3 = 3'd2;
    addr   = 32'h6000;
    tick();
    valid         = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    chk("rw_reqv", 32'(mem_req_valid), 1);
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("rw_busy_wait", 32'(busy), 1);
    chk("rw_load_before", load_data, 32'hDEADBEEF);
    reset_n = 1'b0;
    tick();
    reset_n        = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h12345678;
    #1;
    chk("rw_done", 32'(done), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_load", load_data, 0);
    chk("rw_reqv_idle", 32'(mem_req_valid), 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("rw_done_late", 32'(done), 0);
    chk("rw_load_late", load_data, 0);
    chk("rw_busy_late", 32'(busy), 0);
    chk("rw_err_late", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
